// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: tracks EX/MEM/WB register tags
// and drives forwarding selects, load-use stall, branch flush and data-memory wait stall.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module pipe_hazard_unit #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
);

    localparam int WAIT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              ex_uses_rs1;
    logic              ex_uses_rs2;

    logic              mem_valid;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;

    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;

    logic [WAIT_W-1:0] wait_cnt;

    logic mem_wait;
    logic load_use;
    logic branch;
    logic load_enters_mem;

    assign mem_wait = (wait_cnt != '0);
    assign branch   = ex_branch_taken & ~mem_wait;
    assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign load_enters_mem = ~mem_wait & ex_valid & ex_mem_read;

    // A held memory wait outranks a branch, which stays asserted and is taken once the wait ends
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (branch) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    function automatic logic [1:0] fwd_sel(
        input logic              used,
        input logic [REG_AW-1:0] src,
        input logic              ex_v,
        input logic              m_v,
        input logic              m_rw,
        input logic              m_mr,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_v,
        input logic              w_rw,
        input logic [REG_AW-1:0] w_rd
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (ex_v && used) begin
            if (m_v && m_rw && !m_mr && (m_rd != '0) && (m_rd == src)) begin
                sel = FWD_MEM;
            end else if (w_v && w_rw && (w_rd != '0) && (w_rd == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    assign fwd_a = fwd_sel(ex_uses_rs1, ex_rs1, ex_valid,
                           mem_valid, mem_reg_write, mem_mem_read, mem_rd,
                           wb_valid, wb_reg_write, wb_rd);
    assign fwd_b = fwd_sel(ex_uses_rs2, ex_rs2, ex_valid,
                           mem_valid, mem_reg_write, mem_mem_read, mem_rd,
                           wb_valid, wb_reg_write, wb_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_uses_rs1  <= 1'b0;
            ex_uses_rs2  <= 1'b0;
        end else if (!mem_wait) begin
            if (flush_e) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid     <= id_valid;
                ex_rd        <= id_rd;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
                ex_rs1       <= id_rs1;
                ex_rs2       <= id_rs2;
                ex_uses_rs1  <= id_uses_rs1;
                ex_uses_rs2  <= id_uses_rs2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
        end else if (!mem_wait) begin
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            mem_mem_read  <= ex_mem_read;
        end
    end

    // WB receives a bubble for every cycle the load is stuck in MEM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
        end else if (!mem_wait) begin
            wb_valid     <= mem_valid;
            wb_rd        <= mem_rd;
            wb_reg_write <= mem_reg_write;
        end else begin
            wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((MEM_LAT > 0) && load_enters_mem) begin
            wait_cnt <= WAIT_W'(MEM_LAT);
        end else if (mem_wait) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Saturating so a long run never wraps back to a misleadingly small count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_d && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt = stall_cnt;
    assign perf_flush_cnt = flush_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: one instance with single-cycle memory, one with MEM_LAT=2.
// Expected per-cycle outputs are queued at stimulus time and popped when the outputs are sampled.
module tb_pipe_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 32;

`ifdef HAZARD_PERF_EN
    localparam int PERF_STALL0 = 3;
    localparam int PERF_FLUSH0 = 2;
    localparam int PERF_STALL1 = 4;
    localparam int PERF_FLUSH1 = 1;
`else
    localparam int PERF_STALL0 = 0;
    localparam int PERF_FLUSH0 = 0;
    localparam int PERF_STALL1 = 0;
    localparam int PERF_FLUSH1 = 0;
`endif

    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_LU   = 4'b1100;
    localparam logic [3:0] S_MW   = 4'b1111;
    localparam logic [1:0] F_NONE = 2'b00;
    localparam logic [1:0] F_E    = 2'b01;
    localparam logic [1:0] F_DE   = 2'b11;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] st;
        logic [1:0] fl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic          id_valid        [2];
    logic [AW-1:0] id_rs1          [2];
    logic [AW-1:0] id_rs2          [2];
    logic [AW-1:0] id_rd           [2];
    logic          id_uses_rs1     [2];
    logic          id_uses_rs2     [2];
    logic          id_reg_write    [2];
    logic          id_mem_read     [2];
    logic          ex_branch_taken [2];
    logic [1:0]    fwd_a           [2];
    logic [1:0]    fwd_b           [2];
    logic          stall_f         [2];
    logic          stall_d         [2];
    logic          stall_e         [2];
    logic          stall_m         [2];
    logic          flush_d         [2];
    logic          flush_e         [2];
    logic [CW-1:0] perf_stall_cnt  [2];
    logic [CW-1:0] perf_flush_cnt  [2];

    exp_t  exp_q [$];
    int    dut_q [$];
    string tag_q [$];

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.REG_AW(AW), .MEM_LAT(0), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid[0]), .id_rs1(id_rs1[0]), .id_rs2(id_rs2[0]), .id_rd(id_rd[0]),
        .id_uses_rs1(id_uses_rs1[0]), .id_uses_rs2(id_uses_rs2[0]),
        .id_reg_write(id_reg_write[0]), .id_mem_read(id_mem_read[0]),
        .ex_branch_taken(ex_branch_taken[0]),
        .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]),
        .stall_f(stall_f[0]), .stall_d(stall_d[0]), .stall_e(stall_e[0]), .stall_m(stall_m[0]),
        .flush_d(flush_d[0]), .flush_e(flush_e[0]),
        .perf_stall_cnt(perf_stall_cnt[0]), .perf_flush_cnt(perf_flush_cnt[0])
    );

    pipe_hazard_unit #(.REG_AW(AW), .MEM_LAT(2), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid[1]), .id_rs1(id_rs1[1]), .id_rs2(id_rs2[1]), .id_rd(id_rd[1]),
        .id_uses_rs1(id_uses_rs1[1]), .id_uses_rs2(id_uses_rs2[1]),
        .id_reg_write(id_reg_write[1]), .id_mem_read(id_mem_read[1]),
        .ex_branch_taken(ex_branch_taken[1]),
        .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]),
        .stall_f(stall_f[1]), .stall_d(stall_d[1]), .stall_e(stall_e[1]), .stall_m(stall_m[1]),
        .flush_d(flush_d[1]), .flush_e(flush_e[1]),
        .perf_stall_cnt(perf_stall_cnt[1]), .perf_flush_cnt(perf_flush_cnt[1])
    );

    function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                                input logic [3:0] st, input logic [1:0] fl);
        exp_t e;
        e.fa = fa;
        e.fb = fb;
        e.st = st;
        e.fl = fl;
        return e;
    endfunction

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, expv);
        end
    endtask

    // Drives one decode slot on instance d (the other instance idles) and queues its expected outputs
    task automatic applyStimulus(input int d, input string tag, input logic v,
                                 input int rs1, input int rs2, input int rd,
                                 input logic u1, input logic u2, input logic rw,
                                 input logic mr, input logic br, input exp_t e);
        for (int i = 0; i < 2; i++) begin
            id_valid[i]        = 1'b0;
            id_rs1[i]          = '0;
            id_rs2[i]          = '0;
            id_rd[i]           = '0;
            id_uses_rs1[i]     = 1'b0;
            id_uses_rs2[i]     = 1'b0;
            id_reg_write[i]    = 1'b0;
            id_mem_read[i]     = 1'b0;
            ex_branch_taken[i] = 1'b0;
        end
        id_valid[d]        = v;
        id_rs1[d]          = AW'(rs1);
        id_rs2[d]          = AW'(rs2);
        id_rd[d]           = AW'(rd);
        id_uses_rs1[d]     = u1;
        id_uses_rs2[d]     = u2;
        id_reg_write[d]    = rw;
        id_mem_read[d]     = mr;
        ex_branch_taken[d] = br;
        exp_q.push_back(e);
        dut_q.push_back(d);
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        exp_t  e;
        int    d;
        string tag;
        if (exp_q.size() == 0) begin
            total_cnt++;
            fail_cnt++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e   = exp_q.pop_front();
            d   = dut_q.pop_front();
            tag = tag_q.pop_front();
            check(tag, "fwd_a", 32'(fwd_a[d]), 32'(e.fa));
            check(tag, "fwd_b", 32'(fwd_b[d]), 32'(e.fb));
            check(tag, "stall_fdem",
                  32'({stall_f[d], stall_d[d], stall_e[d], stall_m[d]}), 32'(e.st));
            check(tag, "flush_de", 32'({flush_d[d], flush_e[d]}), 32'(e.fl));
        end
    endtask

    task automatic checkPerf(input int d, input string tag, input int es, input int ef);
        check(tag, "perf_stall_cnt", perf_stall_cnt[d], 32'(es));
        check(tag, "perf_flush_cnt", perf_flush_cnt[d], 32'(ef));
    endtask

    task automatic step(input int d, input string tag, input logic v,
                        input int rs1, input int rs2, input int rd,
                        input logic u1, input logic u2, input logic rw,
                        input logic mr, input logic br, input exp_t e);
        applyStimulus(d, tag, v, rs1, rs2, rd, u1, u2, rw, mr, br, e);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e0;
        e0  = mk(2'b00, 2'b00, S_NONE, F_NONE);
        rst = 1'b1;
        applyStimulus(0, "reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        @(negedge clk);
        checkOutput();
        applyStimulus(1, "reset1", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        #1 checkOutput();
        checkPerf(0, "reset0", 0, 0);
        checkPerf(1, "reset1", 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // back-to-back ALU dependency, MEM forwarding
        step(0, "A1", 1, 1, 2, 5, 1, 1, 1, 0, 0, e0);
        step(0, "A2", 1, 5, 3, 6, 1, 1, 1, 0, 0, e0);
        step(0, "A3", 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b01, 2'b00, S_NONE, F_NONE));
        step(0, "A4", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        // distance-2 dependency, WB forwarding on both operands
        step(0, "B1", 1, 1, 2, 5, 1, 1, 1, 0, 0, e0);
        step(0, "B2", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        step(0, "B3", 1, 5, 5, 7, 1, 1, 1, 0, 0, e0);
        step(0, "B4", 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b10, 2'b10, S_NONE, F_NONE));
        // same with x0 as destination: never forwarded
        step(0, "C1", 1, 1, 2, 0, 1, 1, 1, 0, 0, e0);
        step(0, "C2", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        step(0, "C3", 1, 0, 0, 7, 1, 1, 1, 0, 0, e0);
        step(0, "C4", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        // MEM and WB both hold x5: the younger MEM copy wins
        step(0, "D1", 1, 1, 2, 5, 1, 1, 1, 0, 0, e0);
        step(0, "D2", 1, 3, 4, 5, 1, 1, 1, 0, 0, e0);
        step(0, "D3", 1, 5, 5, 6, 1, 1, 1, 0, 0, e0);
        step(0, "D4", 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b01, 2'b01, S_NONE, F_NONE));
        // load-use on rs1, then WB forwarding of the load
        step(0, "E1", 1, 1, 0, 5, 1, 0, 1, 1, 0, e0);
        step(0, "E2", 1, 5, 1, 6, 1, 1, 1, 0, 0, mk(2'b00, 2'b00, S_LU, F_E));
        step(0, "E3", 1, 5, 1, 6, 1, 1, 1, 0, 0, e0);
        step(0, "E4", 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b10, 2'b00, S_NONE, F_NONE));
        // taken branch wins over a simultaneous load-use
        step(0, "F1", 1, 1, 0, 8, 1, 0, 1, 1, 0, e0);
        step(0, "F2", 1, 8, 0, 9, 1, 0, 1, 0, 1, mk(2'b00, 2'b00, S_NONE, F_DE));
        step(0, "F3", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        // load-use on rs2, then branch alongside WB forwarding on operand B
        step(0, "G1", 1, 2, 0, 10, 1, 0, 1, 1, 0, e0);
        step(0, "G2", 1, 3, 10, 11, 1, 1, 1, 0, 0, mk(2'b00, 2'b00, S_LU, F_E));
        step(0, "G3", 1, 3, 10, 11, 1, 1, 1, 0, 0, e0);
        step(0, "G4", 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(2'b00, 2'b10, S_NONE, F_DE));
        step(0, "G5", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        // third load-use, both operands
        step(0, "H1", 1, 0, 0, 12, 1, 0, 1, 1, 0, e0);
        step(0, "H2", 1, 12, 12, 13, 1, 1, 1, 0, 0, mk(2'b00, 2'b00, S_LU, F_E));
        step(0, "H3", 1, 12, 12, 13, 1, 1, 1, 0, 0, e0);
        step(0, "H4", 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b10, 2'b10, S_NONE, F_NONE));
        // load into x0 never triggers a load-use stall
        step(0, "I1", 1, 1, 0, 0, 1, 0, 1, 1, 0, e0);
        step(0, "I2", 1, 0, 0, 1, 1, 1, 1, 0, 0, e0);
        step(0, "I3", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        checkPerf(0, "perf0", PERF_STALL0, PERF_FLUSH0);

        // MEM_LAT=2: two-cycle wait, WB bubble kills the WB forward
        step(1, "M0", 1, 1, 1, 9, 1, 1, 1, 0, 0, e0);
        step(1, "M1", 1, 1, 0, 5, 1, 0, 1, 1, 0, e0);
        step(1, "M2", 1, 9, 3, 7, 1, 1, 1, 0, 0, e0);
        step(1, "M3", 1, 1, 1, 8, 1, 1, 1, 0, 0, mk(2'b10, 2'b00, S_MW, F_NONE));
        step(1, "M4", 1, 1, 1, 8, 1, 1, 1, 0, 0, mk(2'b00, 2'b00, S_MW, F_NONE));
        step(1, "M5", 1, 1, 1, 8, 1, 1, 1, 0, 0, e0);
        step(1, "M6", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        // branch held through the wait flushes only once the wait ends
        step(1, "N1", 1, 1, 0, 5, 1, 0, 1, 1, 0, e0);
        step(1, "N2", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        step(1, "N3", 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(2'b00, 2'b00, S_MW, F_NONE));
        step(1, "N4", 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(2'b00, 2'b00, S_MW, F_NONE));
        step(1, "N5", 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(2'b00, 2'b00, S_NONE, F_DE));
        step(1, "N6", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        checkPerf(1, "perf1", PERF_STALL1, PERF_FLUSH1);

        // asynchronous reset during the second wait cycle
        step(1, "P1", 1, 1, 0, 5, 1, 0, 1, 1, 0, e0);
        step(1, "P2", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        step(1, "P3", 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b00, 2'b00, S_MW, F_NONE));
        applyStimulus(1, "P4", 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b00, 2'b00, S_MW, F_NONE));
        @(negedge clk);
        checkOutput();
        #1 rst = 1'b1;
        applyStimulus(1, "P4_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);
        #1 checkOutput();
        checkPerf(0, "perf0_rst", 0, 0);
        checkPerf(1, "perf1_rst", 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, "P5", 0, 0, 0, 0, 0, 0, 0, 0, 0, e0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
